// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the cache-to-memory arbiter: bus widths and port identifiers.
package mem_arbiter_pkg;

  localparam int unsigned MEM_DATA_BITS = 128;
  localparam int unsigned CPU_ADDR_BITS = 32;
  localparam int unsigned MEM_ADDR_BITS = CPU_ADDR_BITS - 4;

  localparam logic [0:0] PORT_IC = 1'b0;
  localparam logic [0:0] PORT_DC = 1'b1;

  function automatic logic [0:0] next_grant(input logic [0:0] g);
    return ~g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory request/response bundle; master issues requests, slave accepts them and returns read data.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS = MEM_DATA_BITS
);

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// 1-bit owner FIFO recording which cache issued each outstanding read, in issue order.
module mem_arb_id_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ID_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PW = $clog2(ID_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ID_DEPTH-1:0] mem_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                do_push, do_pop;

  assign full  = (count_q == CW'(ID_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so push is legal at full when popping.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Time-sliced arbiter merging icache and dcache requests onto one memory port,
// steering in-order read responses back to the issuing cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS = MEM_DATA_BITS,
  parameter int unsigned ID_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic_mem,
  mem_arbiter_if.slave  dc_mem,
  mem_arbiter_if.master mem,
  output logic          err_orphan_resp
);

  logic [0:0] g_q, g_d;
  logic       err_q, err_d;
  logic       slot_ok;
  logic       fifo_full, fifo_empty, fifo_head;
  logic       push, pop;

  // Readiness depends only on the grant and downstream state, never on the requester's valid.
  assign slot_ok = reset & mem.req_ready & mem.req_data_ready & ~fifo_full;

  assign ic_mem.req_ready      = slot_ok & (g_q == PORT_IC);
  assign ic_mem.req_data_ready = slot_ok & (g_q == PORT_IC);
  assign dc_mem.req_ready      = slot_ok & (g_q == PORT_DC);
  assign dc_mem.req_data_ready = slot_ok & (g_q == PORT_DC);

  always_comb begin
    mem.req_valid      = 1'b0;
    mem.req_addr       = '0;
    mem.req_rw         = 1'b0;
    mem.req_data_valid = 1'b0;
    mem.req_data_bits  = '0;
    mem.req_data_mask  = '0;
    if (reset) begin
      if (g_q == PORT_IC) begin
        mem.req_valid      = ic_mem.req_valid & slot_ok;
        mem.req_addr       = ic_mem.req_addr;
        mem.req_rw         = ic_mem.req_rw;
        mem.req_data_valid = ic_mem.req_data_valid & slot_ok;
        mem.req_data_bits  = ic_mem.req_data_bits;
        mem.req_data_mask  = ic_mem.req_data_mask;
      end else begin
        mem.req_valid      = dc_mem.req_valid & slot_ok;
        mem.req_addr       = dc_mem.req_addr;
        mem.req_rw         = dc_mem.req_rw;
        mem.req_data_valid = dc_mem.req_data_valid & slot_ok;
        mem.req_data_bits  = dc_mem.req_data_bits;
        mem.req_data_mask  = dc_mem.req_data_mask;
      end
    end
  end

  assign push = mem.req_valid & ~mem.req_rw;
  assign pop  = reset & mem.resp_valid & ~fifo_empty;

  assign ic_mem.resp_valid = pop & (fifo_head == PORT_IC);
  assign dc_mem.resp_valid = pop & (fifo_head == PORT_DC);
  assign ic_mem.resp_data  = mem.resp_data;
  assign dc_mem.resp_data  = mem.resp_data;

  assign g_d   = next_grant(g_q);
  assign err_d = err_q | (mem.resp_valid & fifo_empty);
  assign err_orphan_resp = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      g_q   <= PORT_IC;
      err_q <= 1'b0;
    end else begin
      g_q   <= g_d;
      err_q <= err_d;
    end
  end

  mem_arb_id_fifo #(
    .ID_DEPTH(ID_DEPTH)
  ) u_id_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (g_q),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a grant/owner model predicts every output each cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AB    = 28;
  localparam int unsigned DB    = 128;
  localparam int unsigned MB    = DB / 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err;

  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ic_if ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) dc_if ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if ();

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .ID_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_mem         (ic_if),
    .dc_mem         (dc_if),
    .mem            (mem_if),
    .err_orphan_resp(err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit g_m = 1'b0;
  bit err_m = 1'b0;
  bit owner_q[$];
  bit route_log[$];

  task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit port, input bit v, input logic [AB-1:0] a, input bit rw,
                       input logic [DB-1:0] d, input logic [MB-1:0] m);
    if (port == PORT_IC) begin
      ic_if.req_valid = v; ic_if.req_addr = a; ic_if.req_rw = rw;
      ic_if.req_data_valid = v & rw; ic_if.req_data_bits = d; ic_if.req_data_mask = m;
    end else begin
      dc_if.req_valid = v; dc_if.req_addr = a; dc_if.req_rw = rw;
      dc_if.req_data_valid = v & rw; dc_if.req_data_bits = d; dc_if.req_data_mask = m;
    end
  endtask

  // One clock: compare every output at negedge against the model, then advance the model.
  task automatic cycle();
    logic slot, gv, grw, gdv, exp_v;
    logic [AB-1:0] ga;
    logic [DB-1:0] gd;
    logic [MB-1:0] gm;
    bit o;
    @(negedge clk);
    slot = reset & mem_if.req_ready & mem_if.req_data_ready & (owner_q.size() < DEPTH);
    check("ic_ready",      ic_if.req_ready,      slot & (g_m == PORT_IC));
    check("ic_data_ready", ic_if.req_data_ready, slot & (g_m == PORT_IC));
    check("dc_ready",      dc_if.req_ready,      slot & (g_m == PORT_DC));
    check("dc_data_ready", dc_if.req_data_ready, slot & (g_m == PORT_DC));
    check("err_orphan",    err, err_m);
    if (g_m == PORT_IC) begin
      gv = ic_if.req_valid; grw = ic_if.req_rw; gdv = ic_if.req_data_valid;
      ga = ic_if.req_addr; gd = ic_if.req_data_bits; gm = ic_if.req_data_mask;
    end else begin
      gv = dc_if.req_valid; grw = dc_if.req_rw; gdv = dc_if.req_data_valid;
      ga = dc_if.req_addr; gd = dc_if.req_data_bits; gm = dc_if.req_data_mask;
    end
    exp_v = gv & slot;
    check("mem_req_valid", mem_if.req_valid, exp_v);
    check("mem_req_data_valid", mem_if.req_data_valid, gdv & slot);
    if (!reset) begin
      check("rst_mem_addr", mem_if.req_addr, '0);
      check("rst_mem_data", mem_if.req_data_bits, '0);
    end else if (exp_v) begin
      check("mem_req_addr", mem_if.req_addr, ga);
      check("mem_req_rw",   mem_if.req_rw,   grw);
      check("mem_req_data", mem_if.req_data_bits, gd);
      check("mem_req_mask", mem_if.req_data_mask, gm);
    end
    if (ic_if.resp_valid === 1'b1) route_log.push_back(PORT_IC);
    if (dc_if.resp_valid === 1'b1) route_log.push_back(PORT_DC);
    if (reset && mem_if.resp_valid && owner_q.size() > 0) begin
      o = owner_q.pop_front();
      check("ic_resp_valid", ic_if.resp_valid, (o == PORT_IC));
      check("dc_resp_valid", dc_if.resp_valid, (o == PORT_DC));
      check("ic_resp_data", ic_if.resp_data, mem_if.resp_data);
      check("dc_resp_data", dc_if.resp_data, mem_if.resp_data);
    end else begin
      if (reset && mem_if.resp_valid) err_m = 1'b1;
      check("ic_resp_idle", ic_if.resp_valid, 1'b0);
      check("dc_resp_idle", dc_if.resp_valid, 1'b0);
    end
    if (!reset) begin
      g_m = PORT_IC;
      err_m = 1'b0;
      owner_q.delete();
    end else begin
      if (exp_v && !grw) owner_q.push_back(g_m);
      g_m = ~g_m;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit port, input logic [AB-1:0] a, input bit rw,
                      input logic [DB-1:0] d, input logic [MB-1:0] m);
    for (int i = 0; i < 3 && g_m != port; i++) cycle();
    drive(port, 1'b1, a, rw, d, m);
    cycle();
    drive(port, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic respond(input logic [DB-1:0] d);
    mem_if.resp_valid = 1'b1;
    mem_if.resp_data  = d;
    cycle();
    mem_if.resp_valid = 1'b0;
  endtask

  task automatic check_routes(input string tag, input bit exp[$]);
    check({tag, "_count"}, route_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < route_log.size(); i++)
      check({tag, "_port"}, route_log[i], exp[i]);
    route_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(PORT_IC, 1'b0, '0, 1'b0, '0, '0);
    drive(PORT_DC, 1'b0, '0, 1'b0, '0, '0);
    mem_if.req_ready = 1'b1;
    mem_if.req_data_ready = 1'b1;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_data = '0;
    @(posedge clk); #1;

    // Reset held two cycles with a request pending: nothing may reach memory.
    drive(PORT_IC, 1'b1, 28'h5, 1'b0, '0, '0);
    cycle(); cycle();
    drive(PORT_IC, 1'b0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    cycle(); cycle(); cycle();

    // Single IC read, response three cycles after issue.
    send(PORT_IC, 28'h10, 1'b0, '0, '0);
    cycle(); cycle();
    respond({32{4'hA}});
    check_routes("single", '{PORT_IC});

    // Interleaved back-to-back reads.
    send(PORT_IC, 28'h10, 1'b0, '0, '0);
    send(PORT_DC, 28'h20, 1'b0, '0, '0);
    send(PORT_IC, 28'h11, 1'b0, '0, '0);
    send(PORT_DC, 28'h21, 1'b0, '0, '0);
    respond(128'h1111);
    respond(128'h2222);
    respond(128'h3333);
    respond(128'h4444);
    check_routes("interleave", '{PORT_IC, PORT_DC, PORT_IC, PORT_DC});

    // Fill the owner FIFO, then keep IC pressure on while responses trickle back.
    send(PORT_IC, 28'h30, 1'b0, '0, '0);
    send(PORT_DC, 28'h31, 1'b0, '0, '0);
    send(PORT_IC, 28'h32, 1'b0, '0, '0);
    send(PORT_DC, 28'h33, 1'b0, '0, '0);
    cycle(); cycle();
    check("full_ic_blocked", ic_if.req_ready, 1'b0);
    check("full_dc_blocked", dc_if.req_ready, 1'b0);
    drive(PORT_IC, 1'b1, 28'h40, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      mem_if.resp_valid = (i == 1 || i == 4 || i == 5);
      mem_if.resp_data  = DB'(32'hC000 + i);
      cycle();
    end
    mem_if.resp_valid = 1'b0;
    drive(PORT_IC, 1'b0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 8 && owner_q.size() > 0; k++) respond(DB'(32'hD000 + k));
    check("drained", owner_q.size(), 0);
    route_log.delete();

    // Memory back-pressure removes both grants.
    mem_if.req_ready = 1'b0;
    drive(PORT_IC, 1'b1, 28'h50, 1'b0, '0, '0);
    drive(PORT_DC, 1'b1, 28'h51, 1'b0, '0, '0);
    cycle(); cycle();
    mem_if.req_ready = 1'b1;
    mem_if.req_data_ready = 1'b0;
    cycle(); cycle();
    mem_if.req_data_ready = 1'b1;
    drive(PORT_IC, 1'b0, '0, 1'b0, '0, '0);
    drive(PORT_DC, 1'b0, '0, 1'b0, '0, '0);

    // DC write: passes straight through, queues no owner.
    send(PORT_DC, 28'h33, 1'b1, {96'h0, 32'hDEAD0000}, 16'h00F0);

    // Response with nothing outstanding is an orphan and the flag sticks.
    respond(128'hBAD);
    check_routes("orphan", '{});
    cycle(); cycle(); cycle();
    check("orphan_sticky", err, 1'b1);

    // Reset discards an outstanding read; its late response becomes an orphan.
    send(PORT_IC, 28'h60, 1'b0, '0, '0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check("err_cleared", err, 1'b0);
    respond(128'hFEED);
    cycle();
    check("late_orphan", err, 1'b1);
    check_routes("late", '{});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
